// File: rtl/mcdf_arb_pkg.sv
// Shared types and helpers for the MCDF round-robin packet arbiter.
package mcdf_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int MAX_BEATS = 32;

    // Beats per packet: 4 << sel for sel 0..3, saturating at MAX_BEATS.
    function automatic int pkglen_to_beats(input int unsigned sel);
        if (sel >= 4) begin
            return MAX_BEATS;
        end
        return 4 << sel;
    endfunction

    function automatic int idle_id(input int id_w);
        return (1 << id_w) - 1;
    endfunction

endpackage

// File: rtl/mcdf_prio_rr_pick.sv
// Combinational winner selection: minimum priority value among requesters,
// ties broken by the first matching channel after the round-robin pointer.
module mcdf_prio_rr_pick
    import mcdf_arb_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int PRIO_W = 2,
    parameter int ID_W   = 2
) (
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH*PRIO_W-1:0] prio_i,
    input  logic [ID_W-1:0]          rr_ptr_i,
    output logic [ID_W-1:0]          winner_o,
    output logic                     any_req_o
);

    logic [PRIO_W-1:0] min_prio;
    logic              found;
    int                pos;

    always_comb begin
        min_prio  = '1;
        found     = 1'b0;
        pos       = 0;
        winner_o  = '0;
        any_req_o = |req_i;
        for (int k = 0; k < NUM_CH; k++) begin
            if (req_i[k] && (prio_i[k*PRIO_W +: PRIO_W] < min_prio)) begin
                min_prio = prio_i[k*PRIO_W +: PRIO_W];
            end
        end
        // Walk channels starting just after the pointer, wrapping modulo NUM_CH.
        for (int off = 1; off <= NUM_CH; off++) begin
            pos = (int'(rr_ptr_i) + off) % NUM_CH;
            for (int k = 0; k < NUM_CH; k++) begin
                if (!found && (k == pos) && req_i[k] &&
                    (prio_i[k*PRIO_W +: PRIO_W] == min_prio)) begin
                    winner_o = ID_W'(k);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mcdf_rr_arbiter.sv
// N-channel packet arbiter: priority + round-robin grant held for one packet.
// Optional watchdog abort enabled with the ARB_TIMEOUT_EN macro.
module mcdf_rr_arbiter
    import mcdf_arb_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int DW      = 8,
    parameter int PRIO_W  = 2,
    parameter int LEN_W   = 3,
`ifdef ARB_TIMEOUT_EN
    parameter int TIMEOUT = 255,
`endif
    localparam int ID_W   = $clog2(NUM_CH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [NUM_CH*PRIO_W-1:0] slv_prio_i,
    input  logic [NUM_CH*LEN_W-1:0]  slv_pkglen_i,
    input  logic [NUM_CH*DW-1:0]     slv_data_i,
    input  logic [NUM_CH-1:0]        slv_req_i,
    input  logic [NUM_CH-1:0]        slv_val_i,
    output logic [NUM_CH-1:0]        a2s_ack_o,
    input  logic                     f2a_id_req_i,
    input  logic                     f2a_ack_i,
    output logic                     a2f_val_o,
    output logic [ID_W-1:0]          a2f_id_o,
    output logic [DW-1:0]            a2f_data_o,
    output logic [LEN_W-1:0]         a2f_pkglen_sel_o,
`ifdef ARB_TIMEOUT_EN
    output logic [7:0]               a2f_timeout_o,
`endif
    output logic                     a2f_pkt_done_o
);

    localparam logic [ID_W-1:0] IDLE_ID = ID_W'(idle_id(ID_W));

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [LEN_W-1:0]  pkglen_q, pkglen_d;
    logic [5:0]        cnt_q, cnt_d;
`ifdef ARB_TIMEOUT_EN
    logic [7:0]        wd_q, wd_d;
`endif

    logic [ID_W-1:0]   winner;
    logic              any_req;
    logic [LEN_W-1:0]  win_len;
    logic              gnt_val;
    logic [DW-1:0]     gnt_data;
    logic              beat;
    logic              last_beat;
    logic              done;
    logic              timeout_pulse;

    mcdf_prio_rr_pick #(
        .NUM_CH (NUM_CH),
        .PRIO_W (PRIO_W),
        .ID_W   (ID_W)
    ) u_pick (
        .req_i     (slv_req_i),
        .prio_i    (slv_prio_i),
        .rr_ptr_i  (rr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    always_comb begin
        gnt_val  = 1'b0;
        gnt_data = '1;
        win_len  = '1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (id_q == ID_W'(k)) begin
                gnt_val  = slv_val_i[k];
                gnt_data = slv_data_i[k*DW +: DW];
            end
            if (winner == ID_W'(k)) begin
                win_len = slv_pkglen_i[k*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        a2f_val_o  = 1'b0;
        a2f_data_o = '1;
        a2s_ack_o  = '0;
        if (state_q == XFER) begin
            a2f_val_o  = gnt_val;
            a2f_data_o = gnt_data;
            for (int k = 0; k < NUM_CH; k++) begin
                a2s_ack_o[k] = f2a_ack_i && (id_q == ID_W'(k));
            end
        end
    end

    assign beat      = (state_q == XFER) && f2a_ack_i && gnt_val;
    assign last_beat = beat && (cnt_q == 6'(pkglen_to_beats(32'(pkglen_q)) - 1));

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        rr_d          = rr_q;
        pkglen_d      = pkglen_q;
        cnt_d         = cnt_q;
        done          = 1'b0;
        timeout_pulse = 1'b0;
`ifdef ARB_TIMEOUT_EN
        wd_d          = wd_q;
`endif
        case (state_q)
            IDLE: begin
                if (f2a_id_req_i && any_req) begin
                    state_d  = XFER;
                    id_d     = winner;
                    rr_d     = winner;
                    pkglen_d = win_len;
                    cnt_d    = '0;
`ifdef ARB_TIMEOUT_EN
                    wd_d     = '0;
`endif
                end
            end
            XFER: begin
                if (beat) begin
`ifdef ARB_TIMEOUT_EN
                    wd_d = '0;
`endif
                    if (last_beat) begin
                        done    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                        id_d    = IDLE_ID;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                // A stalled packet is dropped without a done pulse.
                else if (wd_q == 8'(TIMEOUT)) begin
                    timeout_pulse = 1'b1;
                    cnt_d         = '0;
                    wd_d          = '0;
                    state_d       = IDLE;
                    id_d          = IDLE_ID;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                id_d    = IDLE_ID;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            id_q     <= IDLE_ID;
            rr_q     <= ID_W'(NUM_CH - 1);
            pkglen_q <= '1;
            cnt_q    <= '0;
`ifdef ARB_TIMEOUT_EN
            wd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            rr_q     <= rr_d;
            pkglen_q <= pkglen_d;
            cnt_q    <= cnt_d;
`ifdef ARB_TIMEOUT_EN
            wd_q     <= wd_d;
`endif
        end
    end

    assign a2f_id_o         = id_q;
    assign a2f_pkglen_sel_o = pkglen_q;
    assign a2f_pkt_done_o   = done;
`ifdef ARB_TIMEOUT_EN
    assign a2f_timeout_o    = {7'd0, timeout_pulse};
`else
    logic unused_timeout;
    assign unused_timeout = timeout_pulse;
`endif

endmodule

// File: tb/tb_mcdf_rr_arbiter.sv
// Directed self-checking bench for mcdf_rr_arbiter (default 3-channel build;
// the watchdog scenario is included when ARB_TIMEOUT_EN is defined).
module tb_mcdf_rr_arbiter;

    localparam int NUM_CH = 3;
    localparam int DW     = 8;
    localparam int PRIO_W = 2;
    localparam int LEN_W  = 3;
    localparam int ID_W   = 2;

    logic                     clk_i = 1'b0;
    logic                     rstn_i = 1'b0;
    logic [NUM_CH*PRIO_W-1:0] slv_prio_i = '0;
    logic [NUM_CH*LEN_W-1:0]  slv_pkglen_i = '0;
    logic [NUM_CH*DW-1:0]     slv_data_i = {8'hC2, 8'hB1, 8'hA0};
    logic [NUM_CH-1:0]        slv_req_i = '0;
    logic [NUM_CH-1:0]        slv_val_i = '0;
    logic [NUM_CH-1:0]        a2s_ack_o;
    logic                     f2a_id_req_i = 1'b0;
    logic                     f2a_ack_i = 1'b0;
    logic                     a2f_val_o;
    logic [ID_W-1:0]          a2f_id_o;
    logic [DW-1:0]            a2f_data_o;
    logic [LEN_W-1:0]         a2f_pkglen_sel_o;
    logic                     a2f_pkt_done_o;
`ifdef ARB_TIMEOUT_EN
    logic [7:0]               a2f_timeout_o;
`endif

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk_i = ~clk_i;

    mcdf_rr_arbiter #(
        .NUM_CH  (NUM_CH),
        .DW      (DW),
        .PRIO_W  (PRIO_W),
`ifdef ARB_TIMEOUT_EN
        .TIMEOUT (10),
`endif
        .LEN_W   (LEN_W)
    ) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .slv_prio_i       (slv_prio_i),
        .slv_pkglen_i     (slv_pkglen_i),
        .slv_data_i       (slv_data_i),
        .slv_req_i        (slv_req_i),
        .slv_val_i        (slv_val_i),
        .a2s_ack_o        (a2s_ack_o),
        .f2a_id_req_i     (f2a_id_req_i),
        .f2a_ack_i        (f2a_ack_i),
        .a2f_val_o        (a2f_val_o),
        .a2f_id_o         (a2f_id_o),
        .a2f_data_o       (a2f_data_o),
        .a2f_pkglen_sel_o (a2f_pkglen_sel_o),
`ifdef ARB_TIMEOUT_EN
        .a2f_timeout_o    (a2f_timeout_o),
`endif
        .a2f_pkt_done_o   (a2f_pkt_done_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Counts accepted beats from the current XFER cycle until done, bounded.
    task automatic count_packet(output int beats, output bit sawDone);
        beats   = 0;
        sawDone = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (a2f_val_o && f2a_ack_i) beats++;
            if (a2f_pkt_done_o) begin
                sawDone = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        tick();
        tick();
        nChecks++; if (a2f_id_o !== 2'b11) begin nFails++; $display("[TB] FAIL reset_id got=%b want=11", a2f_id_o); end
        nChecks++; if (a2f_val_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_val got=%b want=0", a2f_val_o); end
        nChecks++; if (a2s_ack_o !== 3'b000) begin nFails++; $display("[TB] FAIL reset_ack got=%b want=000", a2s_ack_o); end
        nChecks++; if (a2f_data_o !== 8'hFF) begin nFails++; $display("[TB] FAIL reset_data got=%h want=ff", a2f_data_o); end
        nChecks++; if (a2f_pkglen_sel_o !== 3'b111) begin nFails++; $display("[TB] FAIL reset_pkglen got=%b want=111", a2f_pkglen_sel_o); end
        nChecks++; if (a2f_pkt_done_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done got=%b want=0", a2f_pkt_done_o); end
        rstn_i = 1'b1;
        tick();
        nChecks++; if (a2f_id_o !== 2'b11) begin nFails++; $display("[TB] FAIL idle_after_reset_id got=%b want=11", a2f_id_o); end
    endtask

    task automatic test_single();
        int beats;
        bit sawDone;
        slv_req_i    = 3'b010;
        slv_prio_i   = {2'd0, 2'd2, 2'd0};
        slv_pkglen_i = {3'd0, 3'd0, 3'd0};
        slv_val_i    = 3'b111;
        f2a_ack_i    = 1'b1;
        f2a_id_req_i = 1'b1;
        #1;
        nChecks++; if (a2f_id_o !== 2'b11) begin nFails++; $display("[TB] FAIL single_latency got=%b want=11", a2f_id_o); end
        tick();
        f2a_id_req_i = 1'b0;
        #1;
        nChecks++; if (a2f_id_o !== 2'b01) begin nFails++; $display("[TB] FAIL single_id got=%b want=01", a2f_id_o); end
        nChecks++; if (a2s_ack_o !== 3'b010) begin nFails++; $display("[TB] FAIL single_ack got=%b want=010", a2s_ack_o); end
        nChecks++; if (a2f_data_o !== 8'hB1) begin nFails++; $display("[TB] FAIL single_data got=%h want=b1", a2f_data_o); end
        nChecks++; if (a2f_pkglen_sel_o !== 3'd0) begin nFails++; $display("[TB] FAIL single_pkglen got=%0d want=0", a2f_pkglen_sel_o); end
        count_packet(beats, sawDone);
        nChecks++; if (!sawDone || beats != 4) begin nFails++; $display("[TB] FAIL single_beats got=%0d done=%b want=4 done=1", beats, sawDone); end
        tick();
        nChecks++; if (a2f_id_o !== 2'b11) begin nFails++; $display("[TB] FAIL single_release_id got=%b want=11", a2f_id_o); end
        nChecks++; if (a2f_pkt_done_o !== 1'b0 || a2s_ack_o !== 3'b000) begin nFails++; $display("[TB] FAIL single_release_done=%b ack=%b want done=0 ack=000", a2f_pkt_done_o, a2s_ack_o); end
    endtask

    task automatic test_priority();
        int beats;
        bit sawDone;
        slv_req_i    = 3'b111;
        slv_prio_i   = {2'd1, 2'd3, 2'd2};
        slv_pkglen_i = {3'd2, 3'd1, 3'd0};
        f2a_id_req_i = 1'b1;
        tick();
        f2a_id_req_i = 1'b0;
        nChecks++; if (a2f_id_o !== 2'd2) begin nFails++; $display("[TB] FAIL prio_id got=%0d want=2", a2f_id_o); end
        nChecks++; if (a2f_pkglen_sel_o !== 3'd2) begin nFails++; $display("[TB] FAIL prio_pkglen got=%0d want=2", a2f_pkglen_sel_o); end
        // Config and request changes mid-packet must not disturb the grant.
        slv_pkglen_i = '0;
        slv_prio_i   = '0;
        slv_req_i    = 3'b000;
        #1;
        nChecks++; if (a2f_data_o !== 8'hC2) begin nFails++; $display("[TB] FAIL prio_data got=%h want=c2", a2f_data_o); end
        count_packet(beats, sawDone);
        nChecks++; if (!sawDone || beats != 16) begin nFails++; $display("[TB] FAIL prio_beats got=%0d done=%b want=16 done=1", beats, sawDone); end
        tick();
    endtask

    task automatic test_round_robin();
        int beats;
        bit sawDone;
        logic [1:0] order [4];
        order = '{2'd0, 2'd1, 2'd2, 2'd0};
        rstn_i = 1'b0;
        tick();
        rstn_i       = 1'b1;
        slv_req_i    = 3'b111;
        slv_prio_i   = '0;
        slv_pkglen_i = '0;
        f2a_id_req_i = 1'b1;
        for (int p = 0; p < 4; p++) begin
            tick();
            nChecks++; if (a2f_id_o !== order[p]) begin nFails++; $display("[TB] FAIL rr_grant%0d got=%0d want=%0d", p, a2f_id_o, order[p]); end
            count_packet(beats, sawDone);
            nChecks++; if (!sawDone || beats != 4) begin nFails++; $display("[TB] FAIL rr_beats%0d got=%0d done=%b want=4", p, beats, sawDone); end
            tick();
            nChecks++; if (a2f_id_o !== 2'b11) begin nFails++; $display("[TB] FAIL rr_gap%0d got=%b want=11", p, a2f_id_o); end
        end
        f2a_id_req_i = 1'b0;
        tick();
    endtask

    task automatic test_length();
        int beats;
        bit sawDone;
        logic [2:0] sels [2];
        logic [4:0] valPat;
        sels = '{3'd3, 3'd6};
        slv_req_i  = 3'b001;
        slv_prio_i = '0;
        for (int s = 0; s < 2; s++) begin
            slv_pkglen_i = {3'd0, 3'd0, sels[s]};
            f2a_id_req_i = 1'b1;
            tick();
            f2a_id_req_i = 1'b0;
            #1;
            count_packet(beats, sawDone);
            nChecks++; if (!sawDone || beats != 32) begin nFails++; $display("[TB] FAIL len_sel%0d got=%0d done=%b want=32", sels[s], beats, sawDone); end
            tick();
        end
        // Second cycle acks without valid: packet of 4 beats takes 5 cycles.
        valPat       = 5'b11101;
        slv_pkglen_i = '0;
        f2a_id_req_i = 1'b1;
        tick();
        f2a_id_req_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            slv_val_i = {2'b11, valPat[i]};
            #1;
            nChecks++; if (a2f_pkt_done_o !== (i == 4)) begin nFails++; $display("[TB] FAIL noval_done_c%0d got=%b want=%b", i, a2f_pkt_done_o, (i == 4)); end
            if (i == 1) begin
                nChecks++; if (a2s_ack_o !== 3'b001 || a2f_val_o !== 1'b0) begin nFails++; $display("[TB] FAIL noval_ack got ack=%b val=%b want ack=001 val=0", a2s_ack_o, a2f_val_o); end
            end
            tick();
        end
        slv_val_i = 3'b111;
        nChecks++; if (a2f_id_o !== 2'b11) begin nFails++; $display("[TB] FAIL noval_release got=%b want=11", a2f_id_o); end
    endtask

    task automatic test_reset_mid();
        int beats;
        bit sawDone;
        slv_req_i    = 3'b001;
        slv_pkglen_i = {3'd0, 3'd0, 3'd2};
        f2a_id_req_i = 1'b1;
        tick();
        f2a_id_req_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        nChecks++; if (a2f_pkt_done_o !== 1'b0 || a2f_id_o !== 2'd0) begin nFails++; $display("[TB] FAIL mid_beat5 got done=%b id=%0d want done=0 id=0", a2f_pkt_done_o, a2f_id_o); end
        rstn_i = 1'b0;
        tick();
        nChecks++; if (a2f_id_o !== 2'b11 || a2f_val_o !== 1'b0) begin nFails++; $display("[TB] FAIL mid_abort got id=%b val=%b want id=11 val=0", a2f_id_o, a2f_val_o); end
        nChecks++; if (a2s_ack_o !== 3'b000 || a2f_pkt_done_o !== 1'b0) begin nFails++; $display("[TB] FAIL mid_abort got ack=%b done=%b want ack=000 done=0", a2s_ack_o, a2f_pkt_done_o); end
        // Pointer back at NUM_CH-1: channel 0 wins the tie against channel 1.
        rstn_i       = 1'b1;
        slv_req_i    = 3'b011;
        slv_prio_i   = '0;
        slv_pkglen_i = '0;
        f2a_id_req_i = 1'b1;
        tick();
        f2a_id_req_i = 1'b0;
        nChecks++; if (a2f_id_o !== 2'd0) begin nFails++; $display("[TB] FAIL mid_rearb got=%0d want=0", a2f_id_o); end
        #1;
        count_packet(beats, sawDone);
        nChecks++; if (!sawDone || beats != 4) begin nFails++; $display("[TB] FAIL mid_rearb_beats got=%0d done=%b want=4", beats, sawDone); end
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int tmoAt;
        bit doneSeen;
        tmoAt        = -1;
        doneSeen     = 1'b0;
        slv_req_i    = 3'b100;
        f2a_ack_i    = 1'b0;
        f2a_id_req_i = 1'b1;
        tick();
        f2a_id_req_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (a2f_pkt_done_o) doneSeen = 1'b1;
            if (a2f_timeout_o != 8'd0) begin
                tmoAt = i;
                break;
            end
            tick();
        end
        nChecks++; if (tmoAt != 10 || doneSeen) begin nFails++; $display("[TB] FAIL timeout_at got=%0d done=%b want=10 done=0", tmoAt, doneSeen); end
        tick();
        nChecks++; if (a2f_id_o !== 2'b11 || a2f_timeout_o !== 8'd0) begin nFails++; $display("[TB] FAIL timeout_idle got id=%b tmo=%h want id=11 tmo=00", a2f_id_o, a2f_timeout_o); end
        f2a_ack_i = 1'b1;
    endtask
`endif

    initial begin
        $display("[TB] starting mcdf_rr_arbiter bench");
        test_reset();
        test_single();
        test_priority();
        test_round_robin();
        test_length();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
